// File: rtl/kws_sample_feeder.sv
// Buffers upstream PCM samples in a FIFO and replays each utterance to the kws core as
// fixed-length bursts separated by idle gaps. Optional watchdog: define FEEDER_TIMEOUT_EN.
module kws_sample_feeder #(
  parameter int unsigned FIFO_DEPTH = 1024,
  parameter int unsigned BURST_LEN  = 512,
  parameter int unsigned GAP_LEN    = 512,
  parameter int unsigned UTT_LEN    = 16000,
  parameter int unsigned TIMEOUT    = 45000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_s_data,
  input  logic        i_s_valid,
  output logic        o_s_ready,
  input  logic        i_start,
  output logic        o_busy,
  output logic [15:0] o_kws_in,
  output logic        o_kws_in_valid,
  input  logic [3:0]  i_kws_out,
  input  logic        i_kws_out_valid,
  output logic [3:0]  o_label,
  output logic        o_done,
  output logic        o_timeout
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = $clog2(UTT_LEN + 1);
  localparam int unsigned GW = $clog2(GAP_LEN + 1);

  localparam logic [CW-1:0] DepthC   = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] UttLenC  = SW'(UTT_LEN);
  localparam logic [SW-1:0] BurstC   = SW'(BURST_LEN);
  localparam logic [GW-1:0] GapLastC = GW'(GAP_LEN - 1);

  typedef enum logic [2:0] {StIdle, StArm, StBurst, StGap, StWaitRes} state_e;

  state_e          r_state, w_state_d;
  logic [15:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [SW-1:0]   r_sent, w_sent_d;
  logic [SW-1:0]   r_left, w_left_d;
  logic [GW-1:0]   r_gap, w_gap_d;
  logic [15:0]     r_kws_in;
  logic            r_kws_in_valid;
  logic [3:0]      r_label, w_label_d;
  logic            r_done, w_done_d;

  logic            w_push, w_pop, w_fifo_ok;
  logic [SW-1:0]   w_remain, w_need;

`ifdef FEEDER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TimeoutLastC = TW'(TIMEOUT - 1);
  logic [TW-1:0]   r_wd, w_wd_d;
  logic            r_timeout, w_timeout_d;
`endif

  assign o_s_ready = (r_count < DepthC);
  assign w_push    = i_s_valid && o_s_ready;
  // ARM only launches a burst once every sample of it is buffered, so no underflow here.
  assign w_pop     = (r_state == StBurst);

  assign w_remain  = UttLenC - r_sent;
  assign w_need    = (w_remain < BurstC) ? w_remain : BurstC;
  assign w_fifo_ok = (32'(r_count) >= 32'(w_need));

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_s_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_kws_in       <= '0;
      r_kws_in_valid <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_pop) begin
        r_kws_in       <= r_mem[r_rd_ptr];
        r_kws_in_valid <= 1'b1;
      end else begin
        r_kws_in       <= '0;
        r_kws_in_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_sent  <= '0;
      r_left  <= '0;
      r_gap   <= '0;
      r_label <= '0;
      r_done  <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
      r_wd      <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      r_sent  <= w_sent_d;
      r_left  <= w_left_d;
      r_gap   <= w_gap_d;
      r_label <= w_label_d;
      r_done  <= w_done_d;
`ifdef FEEDER_TIMEOUT_EN
      r_wd      <= w_wd_d;
      r_timeout <= w_timeout_d;
`endif
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_sent_d  = r_sent;
    w_left_d  = r_left;
    w_gap_d   = r_gap;
    w_label_d = r_label;
    w_done_d  = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
    w_wd_d      = '0;
    w_timeout_d = r_timeout;
`endif
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d = StArm;
          w_sent_d  = '0;
        end
      end
      StArm: begin
        if (w_fifo_ok) begin
          w_state_d = StBurst;
          w_left_d  = w_need;
        end
      end
      StBurst: begin
        w_sent_d = r_sent + SW'(1);
        w_left_d = r_left - SW'(1);
        if (r_left == SW'(1)) begin
          w_gap_d   = '0;
          w_state_d = (w_sent_d == UttLenC) ? StWaitRes : StGap;
        end
      end
      StGap: begin
        w_gap_d = r_gap + GW'(1);
        // The ARM check is folded into the last gap cycle so the idle run is exactly GAP_LEN.
        if (r_gap == GapLastC) begin
          if (w_fifo_ok) begin
            w_state_d = StBurst;
            w_left_d  = w_need;
          end else begin
            w_state_d = StArm;
          end
        end
      end
      StWaitRes: begin
        if (i_kws_out_valid) begin
          w_label_d = i_kws_out;
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end
`ifdef FEEDER_TIMEOUT_EN
        else if (r_wd == TimeoutLastC) begin
          w_timeout_d = 1'b1;
          w_done_d    = 1'b1;
          w_state_d   = StIdle;
        end else begin
          w_wd_d = r_wd + TW'(1);
        end
`endif
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign o_busy         = (r_state != StIdle);
  assign o_kws_in       = r_kws_in;
  assign o_kws_in_valid = r_kws_in_valid;
  assign o_label        = r_label;
  assign o_done         = r_done;
`ifdef FEEDER_TIMEOUT_EN
  assign o_timeout      = r_timeout;
`else
  assign o_timeout      = 1'b0;
`endif

endmodule
